// File: rtl/fire_burst_encoder.sv
// fire_burst_encoder: turns each rising edge of a fire command into a 5-5-5 optical burst followed by a guard lockout
// Ports: i_clk_50M clock; i_rst async active-high reset; i_en channel enable (checked only in IDLE);
//        i_fire async level fire command; o_opt optical drive; o_busy FSM not IDLE;
//        o_overlap 1-cycle pulse when an edge is dropped; o_burst_cnt bursts started (wrapping).
// Option: define FIRE_BURST_FILTER_EN to require i_fire to stay high MIN_FIRE_CYC clocks before a burst.
module fire_burst_encoder #(
    parameter int PULSE_HIGH   = 250,
    parameter int PULSE_LOW    = 250,
    parameter int PULSE_NUM    = 3,
    parameter int GUARD_CYC    = 2500,
    parameter int MIN_FIRE_CYC = 50,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk_50M,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_fire,
    output logic             o_opt,
    output logic             o_busy,
    output logic             o_overlap,
    output logic [CNT_W-1:0] o_burst_cnt
);
`ifdef FIRE_BURST_FILTER_EN
    typedef enum logic [2:0] {IDLE, HIGH, LOW, GUARD, FILTER} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW, GUARD} state_t;
`endif
    if (PULSE_NUM < 2 || PULSE_NUM > 15 || MIN_FIRE_CYC < 1) begin : g_bad_params
        $error("fire_burst_encoder: illegal parameters");
    end
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0] idx, idx_n;
    logic sync1, sync2, hist, fire_edge, start;
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = idx;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (fire_edge && i_en) begin
`ifdef FIRE_BURST_FILTER_EN
                    state_n = FILTER;
`else
                    state_n = HIGH;
                    start   = 1'b1;
`endif
                end
            end
`ifdef FIRE_BURST_FILTER_EN
            FILTER: begin
                if (!sync2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(MIN_FIRE_CYC - 1)) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    start   = 1'b1;
                end
            end
`endif
            HIGH: begin
                if (cnt == CNT_W'(PULSE_HIGH - 1)) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end
            end
            LOW: begin
                if (cnt == CNT_W'(PULSE_LOW - 1)) begin
                    cnt_n   = '0;
                    state_n = (idx == 4'(PULSE_NUM - 1)) ? GUARD : HIGH;
                    idx_n   = (idx == 4'(PULSE_NUM - 1)) ? idx : idx + 4'd1;
                end
            end
            GUARD: begin
                if (cnt == CNT_W'(GUARD_CYC - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
    // Outputs are registered copies of the current state, which sets the 4-clock fire-to-light latency.
    always_ff @(posedge i_clk_50M or posedge i_rst) begin
        if (i_rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            fire_edge   <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            o_opt       <= 1'b0;
            o_busy      <= 1'b0;
            o_overlap   <= 1'b0;
            o_burst_cnt <= '0;
        end else begin
            sync1       <= i_fire;
            sync2       <= sync1;
            hist        <= sync2;
            fire_edge   <= sync2 & ~hist;
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            o_opt       <= state == HIGH;
            o_busy      <= state != IDLE;
            o_overlap   <= fire_edge && state != IDLE;
            o_burst_cnt <= o_burst_cnt + CNT_W'(start);
        end
    end
endmodule

// File: tb/tb_fire_burst_encoder.sv
// tb_fire_burst_encoder: directed table and sequence checks of fire_burst_encoder
module tb_fire_burst_encoder;
    logic i_clk_50M = 1'b0;
    logic i_rst = 1'b1;
    logic i_en = 1'b1;
    logic i_fire = 1'b0;
    logic o_opt, o_busy, o_overlap;
    logic [15:0] o_burst_cnt;
    logic en_s = 1'b1;
    logic fire_s = 1'b0;
    logic opt_s, busy_s, ovl_s;
    logic [2:0] cnt_s;
`ifdef FIRE_BURST_FILTER_EN
    localparam int FL = 50;
`else
    localparam int FL = 0;
`endif
    typedef struct {
        int   off;
        logic opt;
        logic busy;
        int   dcnt;
    } vec_t;
    vec_t tbl[14];
    int checks = 0;
    int errors = 0;
    int t = 0;
    int rises = 0;
    int highs = 0;
    int ovl = 0;
    int rises_s = 0;
    int exp_cnt = 0;
    logic prev_opt = 1'b0;
    logic prev_s = 1'b0;
    int base, base2, base3;

    fire_burst_encoder dut (
        .i_clk_50M(i_clk_50M), .i_rst(i_rst), .i_en(i_en), .i_fire(i_fire),
        .o_opt(o_opt), .o_busy(o_busy), .o_overlap(o_overlap), .o_burst_cnt(o_burst_cnt)
    );
    fire_burst_encoder #(
        .PULSE_HIGH(2), .PULSE_LOW(2), .PULSE_NUM(2), .GUARD_CYC(3), .MIN_FIRE_CYC(2), .CNT_W(3)
    ) dut_s (
        .i_clk_50M(i_clk_50M), .i_rst(i_rst), .i_en(en_s), .i_fire(fire_s),
        .o_opt(opt_s), .o_busy(busy_s), .o_overlap(ovl_s), .o_burst_cnt(cnt_s)
    );

    always #10 i_clk_50M = ~i_clk_50M;

    task automatic tick();
        @(negedge i_clk_50M);
        t++;
        if (o_opt && !prev_opt) rises++;
        if (o_opt) highs++;
        if (o_overlap) ovl++;
        prev_opt = o_opt;
        if (opt_s && !prev_s) rises_s++;
        prev_s = opt_s;
    endtask

    task automatic wait_abs(input int when);
        while (t < when) tick();
    endtask

    task automatic wait_off(input int b, input int off);
        wait_abs(b + FL + off);
    endtask

    task automatic clr();
        rises = 0;
        highs = 0;
        ovl = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{2, 1'b0, 1'b0, 0};
        tbl[1]  = '{3, 1'b0, 1'b0, 1};
        tbl[2]  = '{4, 1'b1, 1'b1, 1};
        tbl[3]  = '{253, 1'b1, 1'b1, 1};
        tbl[4]  = '{254, 1'b0, 1'b1, 1};
        tbl[5]  = '{503, 1'b0, 1'b1, 1};
        tbl[6]  = '{504, 1'b1, 1'b1, 1};
        tbl[7]  = '{753, 1'b1, 1'b1, 1};
        tbl[8]  = '{754, 1'b0, 1'b1, 1};
        tbl[9]  = '{1004, 1'b1, 1'b1, 1};
        tbl[10] = '{1254, 1'b0, 1'b1, 1};
        tbl[11] = '{1504, 1'b0, 1'b1, 1};
        tbl[12] = '{4003, 1'b0, 1'b1, 1};
        tbl[13] = '{4004, 1'b0, 1'b0, 1};

        repeat (3) tick();
        chk("rst_opt", int'(o_opt), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ovl", int'(o_overlap), 0);
        chk("rst_cnt", int'(o_burst_cnt), 0);
        i_rst = 1'b0;
        repeat (5) tick();
        chk("idle_busy", int'(o_busy), 0);

        // single burst with i_fire held well past the guard
        clr();
        i_fire = 1'b1;
        base = t + 1;
        foreach (tbl[i]) begin
            wait_off(base, tbl[i].off);
            chk($sformatf("tbl%0d_opt@%0d", i, tbl[i].off), int'(o_opt), int'(tbl[i].opt));
            chk($sformatf("tbl%0d_busy@%0d", i, tbl[i].off), int'(o_busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt@%0d", i, tbl[i].off), int'(o_burst_cnt), exp_cnt + tbl[i].dcnt);
        end
        exp_cnt++;
        wait_off(base, 4500);
        chk("hold_busy", int'(o_busy), 0);
        chk("hold_cnt", int'(o_burst_cnt), exp_cnt);
        chk("hold_rises", rises, 3);
        chk("hold_highs", highs, 750);
        chk("hold_ovl", ovl, 0);
        i_fire = 1'b0;
        repeat (5) tick();

        // second edge 1000 clocks into the burst
        clr();
        i_fire = 1'b1;
        base = t + 1;
        wait_off(base, 100);
        i_fire = 1'b0;
        wait_off(base, 999);
        i_fire = 1'b1;
        wait_off(base, 1002);
        chk("ovl_before", int'(o_overlap), 0);
        wait_off(base, 1003);
        chk("ovl_pulse", int'(o_overlap), 1);
        wait_off(base, 1004);
        chk("ovl_after", int'(o_overlap), 0);
        i_fire = 1'b0;
        exp_cnt++;
        wait_off(base, 4004);
        chk("ovl_rises", rises, 3);
        chk("ovl_count", ovl, 1);
        chk("ovl_cnt", int'(o_burst_cnt), exp_cnt);
        chk("ovl_busy", int'(o_busy), 0);
        repeat (5) tick();

        // edge in the last guard clock is dropped, edge after busy falls is accepted
        clr();
        i_fire = 1'b1;
        base = t + 1;
        wait_off(base, 100);
        i_fire = 1'b0;
        wait_off(base, 3999);
        i_fire = 1'b1;
        wait_off(base, 4000);
        i_fire = 1'b0;
        wait_off(base, 4003);
        chk("guard_ovl", int'(o_overlap), 1);
        wait_off(base, 4004);
        chk("guard_busy", int'(o_busy), 0);
        chk("guard_rises", rises, 3);
        exp_cnt++;
        chk("guard_cnt", int'(o_burst_cnt), exp_cnt);
        clr();
        i_fire = 1'b1;
        base2 = t + 1;
        wait_off(base2, 3);
        chk("after_opt3", int'(o_opt), 0);
        wait_off(base2, 4);
        chk("after_opt4", int'(o_opt), 1);
        exp_cnt++;
        chk("after_cnt", int'(o_burst_cnt), exp_cnt);
        wait_off(base2, 100);
        i_fire = 1'b0;

        // edge landing in the first IDLE clock after guard
        wait_off(base2, 4000);
        i_fire = 1'b1;
        base3 = t + 1;
        wait_off(base2, 4004);
        chk("first_idle_busy", int'(o_busy), 0);
        wait_off(base3, 3);
        chk("first_idle_opt3", int'(o_opt), 0);
        wait_off(base3, 4);
        chk("first_idle_opt4", int'(o_opt), 1);
        exp_cnt++;
        chk("first_idle_cnt", int'(o_burst_cnt), exp_cnt);
        wait_off(base3, 100);
        i_fire = 1'b0;
        wait_off(base3, 4004);
        chk("first_idle_rises", rises, 6);
        chk("first_idle_ovl", ovl, 0);
        repeat (5) tick();

        // disabled channel ignores edges; disabling mid-burst lets the burst finish
        clr();
        i_en = 1'b0;
        i_fire = 1'b1;
        repeat (30 + FL) tick();
        chk("dis_busy", int'(o_busy), 0);
        chk("dis_rises", rises, 0);
        chk("dis_ovl", ovl, 0);
        chk("dis_cnt", int'(o_burst_cnt), exp_cnt);
        i_fire = 1'b0;
        repeat (5) tick();
        i_en = 1'b1;
        i_fire = 1'b1;
        base = t + 1;
        wait_off(base, 100);
        i_fire = 1'b0;
        wait_off(base, 600);
        i_en = 1'b0;
        exp_cnt++;
        wait_off(base, 4003);
        chk("en_drop_busy", int'(o_busy), 1);
        wait_off(base, 4004);
        chk("en_drop_idle", int'(o_busy), 0);
        chk("en_drop_rises", rises, 3);
        chk("en_drop_highs", highs, 750);
        chk("en_drop_cnt", int'(o_burst_cnt), exp_cnt);
        i_en = 1'b1;
        repeat (5) tick();

        // asynchronous reset during a high phase
        clr();
        i_fire = 1'b1;
        base = t + 1;
        wait_off(base, 5);
        i_fire = 1'b0;
        wait_off(base, 10);
        chk("mid_opt", int'(o_opt), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("async_opt", int'(o_opt), 0);
        chk("async_cnt", int'(o_burst_cnt), 0);
        chk("async_busy", int'(o_busy), 0);
        exp_cnt = 0;
        repeat (3) tick();
        i_rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_busy", int'(o_busy), 0);
        clr();
        i_fire = 1'b1;
        base = t + 1;
        wait_off(base, 4);
        chk("post_rst_opt", int'(o_opt), 1);
        wait_off(base, 100);
        i_fire = 1'b0;
        exp_cnt++;
        wait_off(base, 4004);
        chk("post_rst_rises", rises, 3);
        chk("post_rst_cnt", int'(o_burst_cnt), exp_cnt);
        repeat (5) tick();

`ifdef FIRE_BURST_FILTER_EN
        clr();
        i_fire = 1'b1;
        base = t + 1;
        wait_abs(base + 19);
        i_fire = 1'b0;
        wait_abs(base + 80);
        chk("glitch_busy", int'(o_busy), 0);
        chk("glitch_rises", rises, 0);
        chk("glitch_cnt", int'(o_burst_cnt), exp_cnt);
        i_fire = 1'b1;
        base = t + 1;
        wait_abs(base + 53);
        chk("filt_opt53", int'(o_opt), 0);
        wait_abs(base + 54);
        chk("filt_opt54", int'(o_opt), 1);
        wait_abs(base + 99);
        i_fire = 1'b0;
        exp_cnt++;
        wait_abs(base + 4054);
        chk("filt_cnt", int'(o_burst_cnt), exp_cnt);
        chk("filt_rises", rises, 3);
`endif

        // small instance: 2-pulse bursts and counter wrap 7 -> 0
        for (int i = 0; i < 8; i++) begin
            fire_s = 1'b1;
            repeat (4) tick();
            fire_s = 1'b0;
            repeat (30) tick();
            chk($sformatf("wrap_cnt%0d", i), int'(cnt_s), (i + 1) % 8);
        end
        chk("wrap_rises", rises_s, 16);
        chk("wrap_busy", int'(busy_s), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
